vx_index_retire: RTL

- Response-side consumer of the slot allocator.
- Accepts tagged, possibly multi-beat responses, where each tag is a slot index issued at request time.
- For each response it looks up the request metadata stored at that index and forwards response plus metadata downstream through a valid/ready stage.
- On the last beat of a tag it frees the slot (release_slot/release_addr).
- Sits between the memory/unit response port and the requesting pipeline, e.g. cache MSHR or LSU return path.

---
 rtl/vx_index_retire_pkg.sv | 9 +
 rtl/vx_index_retire_buf.sv | 43 ++++
 rtl/vx_index_retire.sv | 105 ++++++++++
 3 files changed

// File: rtl/vx_index_retire_pkg.sv
// Shared helpers for the index-retire response path.
package vx_index_retire_pkg;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int unsigned log2up(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_index_retire_buf.sv
// Single-entry elastic stage; OUT_REG selects registered or pass-through.
module vx_index_retire_buf #(
    parameter int unsigned DATAW   = 1,
    parameter int unsigned OUT_REG = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out
);

    if (OUT_REG != 0) begin : g_reg
        logic             valid_q;
        logic [DATAW-1:0] data_q;

        // Room when empty or when the held entry leaves this cycle.
        assign ready_in = ~valid_q | ready_out;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (ready_in) begin
                valid_q <= valid_in;
                if (valid_in) begin
                    data_q <= data_in;
                end
            end
        end

        assign valid_out = valid_q;
        assign data_out  = data_q;
    end else begin : g_pass
        assign ready_in  = ready_out;
        assign valid_out = valid_in;
        assign data_out  = data_in;
    end

endmodule

// File: rtl/vx_index_retire.sv
// Retires tagged responses: joins slot metadata, numbers beats per tag,
// and frees the slot on the last beat.
module vx_index_retire
    import vx_index_retire_pkg::*;
#(
    parameter  int unsigned DATAW     = 1,
    parameter  int unsigned RSP_DATAW = 1,
    parameter  int unsigned SIZE      = 1,
    parameter  int unsigned MAX_BEATS = 1,
    parameter  int unsigned OUT_REG   = 1,
    localparam int unsigned ADDRW     = log2up(SIZE),
    localparam int unsigned BEATW     = log2up(MAX_BEATS)
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 rsp_valid_in,
    input  logic [ADDRW-1:0]     rsp_tag_in,
    input  logic [RSP_DATAW-1:0] rsp_data_in,
    input  logic                 rsp_eop_in,
    output logic                 rsp_ready_in,

    output logic [ADDRW-1:0]     read_addr,
    input  logic [DATAW-1:0]     read_data,

    output logic [ADDRW-1:0]     release_addr,
    output logic                 release_slot,

    output logic                 rsp_valid_out,
    output logic [ADDRW-1:0]     rsp_tag_out,
    output logic [DATAW-1:0]     rsp_meta_out,
    output logic [RSP_DATAW-1:0] rsp_data_out,
    output logic [BEATW-1:0]     rsp_beat_out,
    output logic                 rsp_eop_out,
    input  logic                 rsp_ready_out
);

    localparam int unsigned NSLOT = 1 << ADDRW;
    localparam int unsigned PAYW  = ADDRW + DATAW + RSP_DATAW + BEATW + 1;

    logic             fire_in;
    logic [BEATW-1:0] beat_cur;
    logic [PAYW-1:0]  pay_in;
    logic [PAYW-1:0]  pay_out;

    assign fire_in      = rsp_valid_in & rsp_ready_in;
    assign read_addr    = rsp_tag_in;
    assign release_addr = rsp_tag_in;
    // Safe to free now: metadata is captured by the output stage this cycle.
    assign release_slot = fire_in & rsp_eop_in;

    if (MAX_BEATS > 1) begin : g_cnt
        logic [BEATW-1:0] cnt_q [NSLOT];
        logic             last_beat;

        assign beat_cur  = cnt_q[rsp_tag_in];
        assign last_beat = (beat_cur == BEATW'(MAX_BEATS - 1));

        // Per-tag beat counter; overflow wraps to keep the table sane.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < NSLOT; i++) begin
                    cnt_q[i] <= '0;
                end
            end else if (fire_in) begin
                if (rsp_eop_in || last_beat) begin
                    cnt_q[rsp_tag_in] <= '0;
                end else begin
                    cnt_q[rsp_tag_in] <= beat_cur + BEATW'(1);
                end
            end
        end

        a_beat_overflow : assert property (
            @(posedge clk) disable iff (!reset_n)
            !(fire_in && !rsp_eop_in && last_beat)
        ) else $error("vx_index_retire: non-eop beat past MAX_BEATS on tag %0d", rsp_tag_in);
    end else begin : g_single
        assign beat_cur = '0;

        a_single_eop : assert property (
            @(posedge clk) disable iff (!reset_n)
            !(fire_in && !rsp_eop_in)
        ) else $error("vx_index_retire: single-beat response without eop on tag %0d", rsp_tag_in);
    end

    assign pay_in = {rsp_tag_in, read_data, rsp_data_in, beat_cur, rsp_eop_in};

    vx_index_retire_buf #(
        .DATAW   (PAYW),
        .OUT_REG (OUT_REG)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (rsp_valid_in),
        .ready_in  (rsp_ready_in),
        .data_in   (pay_in),
        .valid_out (rsp_valid_out),
        .ready_out (rsp_ready_out),
        .data_out  (pay_out)
    );

    assign {rsp_tag_out, rsp_meta_out, rsp_data_out, rsp_beat_out, rsp_eop_out} = pay_out;

endmodule
